hazard_sb: RTL and testbench



---
 rtl/hazard_sb_pkg.sv | 16 +
 rtl/hazard_rd_fifo.sv | 80 ++++++++
 rtl/hazard_sb.sv | 141 ++++++++++++++
 tb/tb_hazard_sb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sb_pkg.sv
// Shared types for the hazard controller: register address, Decode class bits, default depth.
package common;

    localparam int unsigned HZ_NREG  = 32;
    localparam int unsigned HZ_DEPTH = 2;
    localparam int unsigned HZ_REG_W = $clog2(HZ_NREG);

    typedef logic [HZ_REG_W-1:0] creg_addr_t;

    typedef struct packed {
        logic branch;
        logic jump;
        logic longop;
    } hz_ctl_t;

endpackage

// File: rtl/hazard_rd_fifo.sv
// In-order FIFO of outstanding long-op destination registers, exposing every entry for the
// parallel busy compare.
module hazard_rd_fifo
    import common::*;
#(
    parameter int unsigned DEPTH = HZ_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  creg_addr_t                   wr_rd,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic [DEPTH-1:0]             ent_valid,
    output creg_addr_t [DEPTH-1:0]       ent_rd
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    creg_addr_t [DEPTH-1:0] rd_q, rd_d;
    logic                   pop_ok, push_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign pop_ok  = pop & (count_q != '0);
    // At full a push is only accepted together with a pop.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        rd_d     = rd_q;
        // Clear before set so a push/pop on the same slot (full) leaves it valid.
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]    = wr_rd;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            rd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            rd_q     <= rd_d;
        end
    end

    assign count     = count_q;
    assign ent_valid = valid_q;
    assign ent_rd    = rd_q;

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard controller: long-op scoreboard, load-use/branch stalls, pending redirect.
// Define HAZARD_PERF_EN to build the saturating Decode-stall performance counter.
module hazard_sb
    import common::*;
#(
    parameter int unsigned NREG   = HZ_NREG,
    parameter int unsigned DEPTH  = HZ_DEPTH,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  creg_addr_t        rs1D,
    input  creg_addr_t        rs2D,
    input  logic              use_rs1D,
    input  logic              use_rs2D,
    input  hz_ctl_t           ctlD,
    input  logic              regwriteE,
    input  logic              memreadE,
    input  creg_addr_t        writeregE,
    input  logic              memreadM,
    input  creg_addr_t        writeregM,
    input  logic              long_issueE,
    input  creg_addr_t        long_rdE,
    input  logic              long_done,
    input  logic              i_data_ok,
    input  logic              d_data_ok,
    input  logic              branch_taken,
    input  logic              flush_ex,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              sb_full,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    if (NREG != HZ_NREG) begin : g_nreg_check
        $error("creg_addr_t is sized for HZ_NREG registers");
    end

    logic [$clog2(DEPTH+1)-1:0] sb_count;
    logic [DEPTH-1:0]           ent_valid;
    creg_addr_t [DEPTH-1:0]     ent_rd;
    logic                       push, pop;
    logic                       rawstall, lwstall, brstall, structstall, dstall, memwait;
    logic                       pend_q, pend_d, fire;

    function automatic logic is_busy(input creg_addr_t r, input logic [DEPTH-1:0] v,
                                     input creg_addr_t [DEPTH-1:0] rds);
        logic hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v[i] && rds[i] == r) hit = 1'b1;
        end
        return hit && (r != '0);
    endfunction

    assign push = long_issueE & ~stallE & (long_rdE != '0);
    assign pop  = long_done & (sb_count != '0);

    hazard_rd_fifo #(
        .DEPTH (DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wr_rd     (long_rdE),
        .count     (sb_count),
        .full      (sb_full),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    always_comb begin
        rawstall = (use_rs1D & is_busy(rs1D, ent_valid, ent_rd))
                 | (use_rs2D & is_busy(rs2D, ent_valid, ent_rd));
        lwstall  = (memreadE & (writeregE != '0) &
                    ((use_rs1D & (rs1D == writeregE)) | (use_rs2D & (rs2D == writeregE))))
                 | (memreadM & (writeregM != '0) &
                    ((use_rs1D & (rs1D == writeregM)) | (use_rs2D & (rs2D == writeregM))));
        // Branches compare in D, so any in-flight producer of either source field stalls.
        brstall  = (ctlD.branch | ctlD.jump) &
                   ((regwriteE & (writeregE != '0) & ((rs1D == writeregE) | (rs2D == writeregE)))
                  | (memreadM & (writeregM != '0) & ((rs1D == writeregM) | (rs2D == writeregM))));
        structstall = ctlD.longop & sb_full & ~pop;
        dstall   = rawstall | lwstall | brstall | structstall;
        memwait  = ~i_data_ok | ~d_data_ok;
    end

    assign stallF = memwait | dstall;
    assign stallD = memwait | dstall;
    assign stallE = ~d_data_ok;
    assign stallM = ~d_data_ok;

    assign fire   = (branch_taken | pend_q) & ~stallD;
    assign flushD = flush_ex | fire;
    assign flushE = flush_ex | ((dstall | ~i_data_ok) & d_data_ok);
    assign flushM = flush_ex & d_data_ok;
    assign flushW = ~d_data_ok;

    always_comb begin
        pend_d = pend_q;
        if (fire || flush_ex) begin
            pend_d = 1'b0;
        end else if (branch_taken && stallD) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pend_q <= 1'b0;
        else       pend_q <= pend_d;
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (stallD && !(&perf_q)) perf_d = perf_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

    // Completions must never outnumber issues.
    a_done_nonempty: assert property (@(posedge clk) disable iff (reset)
                                      !(long_done && sb_count == '0));

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: expected output vectors are queued as stimulus is
// driven and popped when the DUT outputs are sampled.
module tb_hazard_sb;
    import common::*;

    localparam int unsigned PERF_W = 32;

    // {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, sb_full}
    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_FULL  = 9'b000000001;
    localparam logic [8:0] O_DST   = 9'b110001000;
    localparam logic [8:0] O_DST_F = 9'b110001001;
    localparam logic [8:0] O_FLD   = 9'b000010000;
    localparam logic [8:0] O_FLEX  = 9'b110011100;
    localparam logic [8:0] O_DWAIT = 9'b111100010;

    logic clk, reset;
    creg_addr_t rs1D, rs2D, writeregE, writeregM, long_rdE;
    logic use_rs1D, use_rs2D, regwriteE, memreadE, memreadM, long_issueE, long_done;
    logic i_data_ok, d_data_ok, branch_taken, flush_ex;
    hz_ctl_t ctlD;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, sb_full;
    logic [PERF_W-1:0] perf_stall_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [8:0] exp_q[$];
    logic [PERF_W-1:0] exp_perf;

    hazard_sb #(
        .NREG   (32),
        .DEPTH  (2),
        .PERF_W (PERF_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rs1D           (rs1D),
        .rs2D           (rs2D),
        .use_rs1D       (use_rs1D),
        .use_rs2D       (use_rs2D),
        .ctlD           (ctlD),
        .regwriteE      (regwriteE),
        .memreadE       (memreadE),
        .writeregE      (writeregE),
        .memreadM       (memreadM),
        .writeregM      (writeregM),
        .long_issueE    (long_issueE),
        .long_rdE       (long_rdE),
        .long_done      (long_done),
        .i_data_ok      (i_data_ok),
        .d_data_ok      (d_data_ok),
        .branch_taken   (branch_taken),
        .flush_ex       (flush_ex),
        .stallF         (stallF),
        .stallD         (stallD),
        .stallE         (stallE),
        .stallM         (stallM),
        .flushD         (flushD),
        .flushE         (flushE),
        .flushM         (flushM),
        .flushW         (flushW),
        .sb_full        (sb_full),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        rs1D = '0; rs2D = '0; use_rs1D = 1'b0; use_rs2D = 1'b0; ctlD = '0;
        regwriteE = 1'b0; memreadE = 1'b0; writeregE = '0; memreadM = 1'b0; writeregM = '0;
        long_issueE = 1'b0; long_rdE = '0; long_done = 1'b0;
        i_data_ok = 1'b1; d_data_ok = 1'b1; branch_taken = 1'b0; flush_ex = 1'b0;
    endtask

    // Inputs are already driven (at a negedge); queue the expectation, sample mid-phase,
    // compare, then advance to the next negedge.
    task automatic step(input string tag, input logic [8:0] exp);
        logic [8:0] got, want;
        exp_q.push_back(exp);
        #3;
        got  = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, sb_full};
        want = exp_q.pop_front();
        check_eq(tag, 64'(got), 64'(want));
`ifdef HAZARD_PERF_EN
        check_eq({tag, "/perf"}, 64'(perf_stall_cnt), 64'(exp_perf));
        if (want[7] && !(&exp_perf)) exp_perf = exp_perf + 1'b1;
`else
        check_eq({tag, "/perf"}, 64'(perf_stall_cnt), 64'd0);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_perf = '0;
    endtask

    initial begin
        quiet();
        exp_perf = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step("reset_idle", O_NONE);

        // RAW on a long-op destination
        long_issueE = 1'b1; long_rdE = 5'd5;
        step("mul_x5_issue", O_NONE);
        quiet(); rs1D = 5'd5; use_rs1D = 1'b1;
        step("raw_x5_c1", O_DST);
        step("raw_x5_c2", O_DST);
        long_done = 1'b1;
        step("raw_x5_pop", O_DST);
        long_done = 1'b0;
        step("raw_x5_free", O_NONE);

        // Full scoreboard: structural stall, pop+push keeps count
        quiet(); long_issueE = 1'b1; long_rdE = 5'd3;
        step("issue_x3", O_NONE);
        long_rdE = 5'd4;
        step("issue_x4", O_NONE);
        quiet(); ctlD.longop = 1'b1;
        step("struct_stall", O_DST_F);
        long_done = 1'b1; long_issueE = 1'b1; long_rdE = 5'd6;
        step("struct_pop_push", O_FULL);
        quiet(); rs1D = 5'd3; use_rs1D = 1'b1;
        step("x3_freed_full", O_FULL);
        quiet(); rs2D = 5'd6; use_rs2D = 1'b1;
        step("x6_busy", O_DST_F);
        quiet(); long_done = 1'b1;
        step("drain1", O_FULL);
        step("drain2", O_NONE);
        quiet();
        step("drained", O_NONE);

        // Load-use
        memreadE = 1'b1; writeregE = 5'd7; rs2D = 5'd7; use_rs2D = 1'b1;
        step("lw_e_x7", O_DST);
        writeregE = 5'd0; rs2D = 5'd0;
        step("lw_e_x0", O_NONE);
        quiet(); memreadM = 1'b1; writeregM = 5'd8; rs1D = 5'd8; use_rs1D = 1'b1;
        step("lw_m_x8", O_DST);
        quiet(); ctlD.branch = 1'b1; regwriteE = 1'b1; writeregE = 5'd11; rs2D = 5'd11;
        step("br_e_x11", O_DST);

        // Redirect while fetch stalled is held, then fires once
        quiet(); branch_taken = 1'b1; i_data_ok = 1'b0;
        step("pend_c1", O_DST);
        step("pend_c2", O_DST);
        step("pend_c3", O_DST);
        quiet();
        step("pend_fire", O_FLD);
        step("pend_done", O_NONE);

        // Memory data wait
        d_data_ok = 1'b0;
        step("dmem_wait", O_DWAIT);
        quiet();

        // flush_ex clears pend but leaves the scoreboard alone
        long_issueE = 1'b1; long_rdE = 5'd9;
        step("issue_x9", O_NONE);
        quiet(); branch_taken = 1'b1; i_data_ok = 1'b0;
        step("pend_set", O_DST);
        quiet(); flush_ex = 1'b1; i_data_ok = 1'b0;
        step("flush_ex", O_FLEX);
        quiet();
        step("pend_cleared", O_NONE);
        rs1D = 5'd9; use_rs1D = 1'b1;
        step("x9_still_busy", O_DST);
        long_done = 1'b1;
        step("x9_pop", O_DST);
        long_done = 1'b0;
        step("x9_free", O_NONE);

        // Reset mid-count clears counter and scoreboard
        quiet(); long_issueE = 1'b1; long_rdE = 5'd12;
        step("issue_x12", O_NONE);
        quiet(); d_data_ok = 1'b0;
        step("stall_pre_rst", O_DWAIT);
        do_reset();
        quiet(); rs1D = 5'd12; use_rs1D = 1'b1;
        step("after_reset", O_NONE);
        quiet(); d_data_ok = 1'b0;
        repeat (5) step("stall5", O_DWAIT);
        quiet();
        step("after_stall5", O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
